operacao_memoria_pipe: RTL
==========================

OPERACAO_MEMORIA_PIPE -- requirements
Module: operacao_memoria_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 64, datapath width in bits (>= 8).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: dinA  input  WIDTH  register Ra read value.
REQ-005 SHALL have port: dinB  input  WIDTH  register Rb read value.
REQ-006 SHALL have port: OFFSET  input  WIDTH  sign-extended immediate.
REQ-007 SHALL have port: OP_MEM_I  input  2  operand select.
REQ-008 SHALL have port: ADD_SUB  input  1  0=add, 1=subtract.
REQ-009 SHALL have port: in_valid  input  1  request present.
REQ-010 SHALL have port: in_ready  output  1  request accepted when in_valid&in_ready.
REQ-011 SHALL have port: flush  input  1  synchronous pipeline clear.
REQ-012 SHALL have port: dout  output  WIDTH  ALU result / address.
REQ-013 SHALL have port: doutA, doutB  output  WIDTH each  dinA/dinB captured with the same request.
REQ-014 SHALL have port: flags  output  6  {LT,EQ,V,C,N,Z} (bit5..bit0).
REQ-015 SHALL have port: out_valid  output  1  result present.
REQ-016 SHALL have port: out_ready  input  1  result consumed when out_valid&out_ready.

Function
REQ-017 SHALL select operands: 00 -> (dinA,dinB); 01 -> (dinB,OFFSET); 10 -> (dinA,OFFSET); 11 -> (0,0).
REQ-018 SHALL be a two-stage pipeline: S1 registers selected operands, ADD_SUB, dinA, dinB; S2 registers result, flags, doutA, doutB.
REQ-019 SHALL deliver a result with out_valid high exactly 2 cycles after acceptance when out_ready stays high.
REQ-020 SHALL sustain one accepted request per cycle when out_ready stays high.
REQ-021 SHALL advance S2 when S2 is empty or out_ready is high; S1 advances into S2 under the same condition.
REQ-022 SHALL drive in_ready = !flush & (S1 empty | S1 advancing); in_ready is combinational.
REQ-023 SHALL hold dout, doutA, doutB, flags and out_valid stable while out_valid & !out_ready.
REQ-024 SHALL compute result = in0 + in1 (ADD_SUB=0) or in0 - in1 (two's complement, ADD_SUB=1), modulo 2^WIDTH.
REQ-025 SHALL set flags: Z = result==0; N = result MSB; C = carry out (subtract: 1 when no borrow); V = signed overflow; EQ = in0==in1; LT = in0 < in1 signed.
REQ-026 SHALL, on flush high at a clock edge, clear S1 and S2 valid bits and accept nothing that cycle; flush overrides in_valid and out_ready.
REQ-027 SHALL leave data registers unchanged on flush; only valid bits clear.

Reset
REQ-028 SHALL, while rst_n low, force out_valid=0, in_ready=0, dout=0, doutA=0, doutB=0, flags=0 and both stages empty, independent of clk.
REQ-029 SHALL discard in-flight requests on reset mid-operation; in_ready rises in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL honour macro OPMEM_SAT_EN: when defined, on V=1 dout saturates to max signed (01..1) if in0 is non-negative, else min signed (10..0); flags computed from the unsaturated result.
REQ-031 SHALL, without OPMEM_SAT_EN, output the wrapped result and contain no saturation logic.

Verification
REQ-032 SHALL cover: OP_MEM_I=00, A=5, B=3, ADD_SUB=1, out_ready=1 -> dout=2 after 2 cycles, flags C=1, Z=0, EQ=0, LT=0.
REQ-033 SHALL cover: OP_MEM_I=01, B=0x1000, OFFSET=-8, add -> dout=0xFF8, doutB=0x1000.
REQ-034 SHALL cover: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> V=1, N=1; dout=0x8000_0000_0000_0000 without OPMEM_SAT_EN, 0x7FFF_FFFF_FFFF_FFFF with it.
REQ-035 SHALL cover: back-to-back requests with out_ready low for 3 cycles -> in_ready low after 2 accepts, outputs held, no loss or reorder.
REQ-036 SHALL cover: flush asserted with both stages full and in_valid=1 -> out_valid=0 the next cycle, no accept that cycle.
REQ-037 SHALL cover: rst_n pulsed low mid-stream -> all outputs 0 asynchronously, pipeline empty after release.

Source files
------------

// File: rtl/operacao_memoria_pipe.sv
// Two-stage operand-select / add-sub pipeline with valid/ready handshake on both sides.
// Optional build macro OPMEM_SAT_EN: saturate dout on signed overflow.
module operacao_memoria_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dinA,
  input  logic [WIDTH-1:0] dinB,
  input  logic [WIDTH-1:0] OFFSET,
  input  logic [1:0]       OP_MEM_I,
  input  logic             ADD_SUB,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] doutA,
  output logic [WIDTH-1:0] doutB,
  output logic [5:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MSB = WIDTH - 1;

  logic             s1_valid;
  logic             s1_sub;
  logic [WIDTH-1:0] s1_in0;
  logic [WIDTH-1:0] s1_in1;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;

  logic [WIDTH-1:0] sel0;
  logic [WIDTH-1:0] sel1;
  logic             advance;
  logic             accept;

  always_comb begin
    sel0 = '0;
    sel1 = '0;
    case (OP_MEM_I)
      2'b00: begin
        sel0 = dinA;
        sel1 = dinB;
      end
      2'b01: begin
        sel0 = dinB;
        sel1 = OFFSET;
      end
      2'b10: begin
        sel0 = dinA;
        sel1 = OFFSET;
      end
      default: begin
        sel0 = '0;
        sel1 = '0;
      end
    endcase
  end

  // in_ready is forced low while in reset so no request is taken before release
  assign advance  = !s2_valid | out_ready;
  assign in_ready = rst_n & !flush & (!s1_valid | advance);
  assign accept   = in_valid & in_ready;

  logic [WIDTH-1:0] op1;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_out;
  logic             c_flag;
  logic             v_flag;
  logic             eq_flag;
  logic             lt_flag;
  logic [5:0]       flags_next;

  // Subtraction as in0 + ~in1 + 1, so the adder carry is the "no borrow" flag
  always_comb begin
    op1        = s1_sub ? ~s1_in1 : s1_in1;
    wide       = {1'b0, s1_in0} + {1'b0, op1} + {{WIDTH{1'b0}}, s1_sub};
    res        = wide[MSB:0];
    c_flag     = wide[WIDTH];
    v_flag     = (s1_in0[MSB] == op1[MSB]) & (res[MSB] != s1_in0[MSB]);
    eq_flag    = (s1_in0 == s1_in1);
    lt_flag    = ($signed(s1_in0) < $signed(s1_in1));
    flags_next = {lt_flag, eq_flag, v_flag, c_flag, res[MSB], (res == '0)};
`ifdef OPMEM_SAT_EN
    if (v_flag)
      res_out = s1_in0[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_out = res;
`else
    res_out = res;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sub    <= 1'b0;
      s1_in0    <= '0;
      s1_in1    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      dout      <= '0;
      doutA     <= '0;
      doutB     <= '0;
      flags     <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (accept)
          s1_valid <= 1'b1;
        else if (advance)
          s1_valid <= 1'b0;
        if (advance)
          s2_valid <= s1_valid;
      end

      if (accept) begin
        s1_in0 <= sel0;
        s1_in1 <= sel1;
        s1_sub <= ADD_SUB;
        s1_a   <= dinA;
        s1_b   <= dinB;
      end

      // Flush only drops valid bits; S2 data keeps its last value
      if (!flush && advance && s1_valid) begin
        dout  <= res_out;
        doutA <= s1_a;
        doutB <= s1_b;
        flags <= flags_next;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
